// File: rtl/spi_ram_pkg.sv
// Shared command encodings and FSM state enumeration for the SPI-to-RAM bridge.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RX   = 2'b01,
    EXEC = 2'b10,
    TX   = 2'b11
  } state_t;

endpackage

// File: rtl/spi_ram_bridge_mem.sv
// Single-port RAM for the SPI bridge: synchronous write, registered (read-first) read.
module spi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI slave exposing a 2**ADDR_W x DATA_W RAM through 2-bit-command frames (requires ADDR_W <= DATA_W).
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each data access.
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int F     = DATA_W + 2;
  localparam int CNT_W = $clog2(F);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [F-1:0]      rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
  logic [DATA_W-1:0] mem_rdata, payload;
  logic              mem_we, last_rx, last_tx;
  cmd_t              cmd;

  assign cmd     = cmd_t'(rx_shift[F-1 -: 2]);
  assign payload = rx_shift[DATA_W-1:0];
  assign last_rx = (bit_cnt == CNT_W'(F - 1));
  assign last_tx = (bit_cnt == CNT_W'(DATA_W - 1));
  assign busy    = (state != IDLE);

  // The RAM address sits on rd_addr except during a write, so the registered
  // read data is already valid for rd_addr when an RD_DATA frame reaches EXEC.
  assign mem_we   = (state == EXEC) && !SS_n && (cmd == CMD_WR_DATA);
  assign mem_addr = mem_we ? wr_addr : rd_addr;

  spi_ram_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RX;
        RX:      if (last_rx) state_nxt = EXEC;
        EXEC:    state_nxt = (cmd == CMD_RD_DATA) ? TX : RX;
        TX:      if (last_tx) state_nxt = RX;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO      <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
    end else begin
      frame_err <= SS_n && (((state == RX) && (bit_cnt != '0)) ||
                            (state == EXEC) || (state == TX));
      MISO      <= 1'b0;
      if (SS_n) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        case (state)
          IDLE: bit_cnt <= '0;
          RX: begin
            rx_shift <= {rx_shift[F-2:0], MOSI};
            bit_cnt  <= last_rx ? '0 : bit_cnt + 1'b1;
          end
          EXEC: begin
            case (cmd)
              CMD_WR_ADDR: wr_addr <= payload[ADDR_W-1:0];
              CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                wr_addr <= wr_addr + 1'b1;
`endif
              end
              CMD_RD_ADDR: rd_addr <= payload[ADDR_W-1:0];
              CMD_RD_DATA: begin
                // MSB goes out on this edge so it is visible for the first TX cycle.
                MISO     <= mem_rdata[DATA_W-1];
                tx_shift <= {mem_rdata[DATA_W-2:0], 1'b0};
`ifdef SPI_RAM_AUTOINC_EN
                rd_addr  <= rd_addr + 1'b1;
`endif
              end
              default: ;
            endcase
          end
          TX: begin
            if (!last_tx) MISO <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            bit_cnt  <= last_tx ? '0 : bit_cnt + 1'b1;
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge; read expectations follow SPI_RAM_AUTOINC_EN when it is defined.
module tb_spi_ram_bridge;
  import spi_ram_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int F      = DATA_W + 2;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, busy, frame_err;

  always #5 clk = ~clk;

  spi_ram_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .busy     (busy),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  bit abort_ok = 1'b0;
  bit check_busy = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: collects each TX word from MISO and checks it against the scoreboard.
  int tx_bits = 0;
  logic [DATA_W-1:0] got;
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (!rst && dut.state == TX) begin
      got = {got[DATA_W-2:0], MISO};
      tx_bits++;
      if (tx_bits == DATA_W) begin
        tx_bits = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got %0h expected no read word", got);
        end else begin
          check("rd_data", got, exp_q.pop_front());
        end
      end
    end else begin
      if (tx_bits != 0) begin
        if (!abort_ok) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_len: got %0d bits expected %0d", tx_bits, DATA_W);
        end
        tx_bits = 0;
      end
      check("miso_idle", MISO, 0);
    end
  end

  task automatic step();
    @(negedge clk);
    if (check_busy) check("busy_win", busy, 1);
  endtask

  task automatic begin_window();
    SS_n = 1'b0;
    MOSI = 1'b0;
    step();
    check_busy = 1'b1;
  endtask

  task automatic end_window();
    check_busy = 1'b0;
    SS_n = 1'b1;
    step();
    step();
    check("busy_idle", busy, 0);
  endtask

  task automatic send_frame(input cmd_t cmd, input logic [DATA_W-1:0] payload);
    logic [F-1:0] w;
    w = {cmd, payload};
    for (int i = F - 1; i >= 0; i--) begin
      MOSI = w[i];
      step();
    end
    MOSI = 1'b0;
    step();
    if (cmd == CMD_RD_DATA) repeat (DATA_W) step();
  endtask

  task automatic read_frame(input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
    send_frame(CMD_RD_DATA, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [F-1:0] w;

    repeat (3) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    step();

    // Write/read round trip
    begin_window();
    send_frame(CMD_WR_ADDR, 8'h3C);
    send_frame(CMD_WR_DATA, 8'hA5);
    send_frame(CMD_RD_ADDR, 8'h3C);
    read_frame(8'hA5);
    end_window();
    check("ferr_rw", ferr_cnt, 0);

    // Known contents for later reads
    begin_window();
    send_frame(CMD_WR_ADDR, 8'h00);
    send_frame(CMD_WR_DATA, 8'h5A);
    send_frame(CMD_WR_ADDR, 8'h10);
    send_frame(CMD_WR_DATA, 8'hC3);
    send_frame(CMD_WR_ADDR, 8'h11);
    send_frame(CMD_WR_DATA, 8'h3C);
    send_frame(CMD_WR_ADDR, 8'h40);
    send_frame(CMD_WR_DATA, 8'h66);
    end_window();

    // Burst across the top of the address space
    begin_window();
    send_frame(CMD_WR_ADDR, 8'hFF);
    send_frame(CMD_WR_DATA, 8'h11);
    send_frame(CMD_WR_DATA, 8'h22);
    send_frame(CMD_RD_ADDR, 8'hFF);
    read_frame(AUTOINC ? 8'h11 : 8'h22);
    send_frame(CMD_RD_ADDR, 8'h00);
    read_frame(AUTOINC ? 8'h22 : 8'h5A);
    end_window();

    // Back-to-back reads in one window
    e0 = ferr_cnt;
    begin_window();
    send_frame(CMD_RD_ADDR, 8'h10);
    read_frame(8'hC3);
    read_frame(AUTOINC ? 8'h3C : 8'hC3);
    end_window();
    check("ferr_b2b", ferr_cnt, e0);

    // SS_n rise with zero bit count: no error
    e0 = ferr_cnt;
    begin_window();
    end_window();
    step();
    check("ferr_zero_cnt", ferr_cnt, e0);

    // Abort after 5 bits of WR_DATA 0x77 aimed at 0x40
    begin_window();
    send_frame(CMD_WR_ADDR, 8'h40);
    end_window();
    e0 = ferr_cnt;
    begin_window();
    w = {CMD_WR_DATA, 8'h77};
    for (int i = F - 1; i > F - 6; i--) begin
      MOSI = w[i];
      step();
    end
    check_busy = 1'b0;
    SS_n = 1'b1;
    step();
    step();
    check("abort_ferr", ferr_cnt, e0 + 1);
    check("abort_state", dut.state, IDLE);
    check("abort_busy", busy, 0);
    repeat (3) step();
    check("abort_one_pulse", ferr_cnt, e0 + 1);
    begin_window();
    send_frame(CMD_RD_ADDR, 8'h40);
    read_frame(8'h66);
    end_window();

    // Reset during the 3rd TX bit of RD_DATA
    begin_window();
    send_frame(CMD_RD_ADDR, 8'h10);
    w = {CMD_RD_DATA, 8'h00};
    for (int i = F - 1; i >= 0; i--) begin
      MOSI = w[i];
      step();
    end
    MOSI = 1'b0;
    step();
    step();
    step();
    check_busy = 1'b0;
    abort_ok = 1'b1;
    e0 = ferr_cnt;
    #2;
    rst = 1'b1;
    SS_n = 1'b1;
    #1;
    check("rst_tx_miso", MISO, 0);
    check("rst_tx_busy", busy, 0);
    check("rst_tx_state", dut.state, IDLE);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    abort_ok = 1'b0;
    check("rst_tx_ferr", ferr_cnt, e0);

    // After reset: rd_addr restarted at 0, memory kept, normal operation
    begin_window();
    read_frame(AUTOINC ? 8'h22 : 8'h5A);
    send_frame(CMD_WR_ADDR, 8'h20);
    send_frame(CMD_WR_DATA, 8'h9E);
    send_frame(CMD_RD_ADDR, 8'h20);
    read_frame(8'h9E);
    send_frame(CMD_RD_ADDR, 8'h3C);
    read_frame(8'hA5);
    end_window();

    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
